ahb_imem_slave: RTL and testbench

AHB_IMEM_SLAVE -- requirements
Module: ahb_imem_slave

---
 rtl/ahb_imem_slave_pkg.sv | 43 ++++
 rtl/ahb_imem_slave_if.sv | 34 +++
 rtl/ahb_imem_slave_wrap_addr_gen.sv | 22 ++
 rtl/ahb_imem_slave.sv | 153 +++++++++++++++
 tb/tb_ahb_imem_slave.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ahb_imem_slave_pkg.sv
// ----------------------------------------------------------------------------
// ahb_imem_slave_pkg
// Shared AHB types for the instruction-memory slave: transfer and burst
// encodings, response codes, the slave FSM state set and the legal size code.
// No ports (package).
// ----------------------------------------------------------------------------
package ahb_imem_slave_pkg;

   typedef enum logic [1:0] {
      TRANS_IDLE   = 2'b00,
      TRANS_BUSY   = 2'b01,
      TRANS_NONSEQ = 2'b10,
      TRANS_SEQ    = 2'b11
   } trans_e;

   typedef enum logic [2:0] {
      BURST_SINGLE = 3'b000,
      BURST_INCR   = 3'b001,
      BURST_WRAP4  = 3'b010,
      BURST_INCR4  = 3'b011,
      BURST_WRAP8  = 3'b100,
      BURST_INCR8  = 3'b101,
      BURST_WRAP16 = 3'b110,
      BURST_INCR16 = 3'b111
   } burst_e;

   typedef enum logic {
      HRESP_OKAY  = 1'b0,
      HRESP_ERROR = 1'b1
   } hresp_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_DATA,
      ST_ERR1,
      ST_ERR2
   } state_e;

   // Only 32-bit fetches are served.
   localparam logic [2:0] HSIZE_WORD = 3'b010;

endpackage

// File: rtl/ahb_imem_slave_if.sv
// ----------------------------------------------------------------------------
// ahb_imem_slave_if
// AHB-Lite bus bundle between a master (or decoder/mux) and the instruction
// memory slave. hready is the bus-level ready that the master side drives;
// hreadyout/hresp/hrdata come back from the slave.
//   master modport : drives address/control/hwdata/hready, reads responses
//   slave  modport : reads address/control/hwdata/hready, drives responses
// ----------------------------------------------------------------------------
interface ahb_imem_slave_if;
   import ahb_imem_slave_pkg::*;

   logic        hsel;
   logic [31:0] haddr;
   logic [1:0]  htrans;
   logic [2:0]  hburst;
   logic [2:0]  hsize;
   logic        hwrite;
   logic [31:0] hwdata;
   logic        hready;
   logic        hreadyout;
   logic        hresp;
   logic [31:0] hrdata;

   modport master (
      output hsel, haddr, htrans, hburst, hsize, hwrite, hwdata, hready,
      input  hreadyout, hresp, hrdata
   );

   modport slave (
      input  hsel, haddr, htrans, hburst, hsize, hwrite, hwdata, hready,
      output hreadyout, hresp, hrdata
   );

endinterface

// File: rtl/ahb_imem_slave_wrap_addr_gen.sv
// ----------------------------------------------------------------------------
// wrap_addr_gen
// Combinational expected-next-address for a burst beat.
//   addr      in  32  address of the current beat
//   wrap4     in  1   1: WRAP4 (wrap inside the 16-byte block), 0: INCR
//   next_addr out 32  address the following SEQ beat must carry
// ----------------------------------------------------------------------------
module wrap_addr_gen
   import ahb_imem_slave_pkg::*;
(
   input  logic [31:0] addr,
   input  logic        wrap4,
   output logic [31:0] next_addr
);

   logic [1:0] wrap_idx;

   // Word index inside the 4-word block rolls over 3 -> 0.
   assign wrap_idx  = addr[3:2] + 2'd1;
   assign next_addr = wrap4 ? {addr[31:4], wrap_idx, 2'b00} : addr + 32'd4;

endmodule

// File: rtl/ahb_imem_slave.sv
// ----------------------------------------------------------------------------
// ahb_imem_slave
// Read-only AHB-Lite instruction memory with a fixed number of wait states,
// WRAP4/INCR burst address tracking and two-cycle ERROR responses for
// writes, non-word sizes, misaligned or out-of-range addresses and broken
// bursts.
//   hclk   in   AHB clock
//   hrstn  in   asynchronous active-low reset
//   bus    slave modport of ahb_imem_slave_if
// Parameters: MEM_WORDS (depth, power of two), WAIT_STATES (0..7),
//             INIT_FILE (hex image name; contents left undefined here).
// ----------------------------------------------------------------------------
module ahb_imem_slave
   import ahb_imem_slave_pkg::*;
#(
   parameter int    MEM_WORDS   = 4096,
   parameter int    WAIT_STATES = 1,
   parameter string INIT_FILE   = ""
) (
   input  logic            hclk,
   input  logic            hrstn,
   ahb_imem_slave_if.slave bus
);

   localparam int         IDX_W     = $clog2(MEM_WORDS);
   localparam int         ADDR_W    = IDX_W + 2;
   localparam logic [2:0] WAIT_LOAD = 3'(WAIT_STATES - 1);

   // ROM contents; no write port, so this is never reset.
   logic [31:0] mem_reg [MEM_WORDS];

   state_e      state_reg, state_next;
   logic [2:0]  wait_cnt_reg, wait_cnt_next;
   logic [1:0]  beat_cnt_reg, beat_cnt_next;
   logic        burst_active_reg, burst_active_next;
   logic        burst_wrap_reg, burst_wrap_next;
   logic [31:0] exp_addr_reg, exp_addr_next;
   logic [31:0] hrdata_reg;

   logic             ready_state, accept, idle_seen, is_nonseq;
   logic             wrap_sel, base_ok, seq_ok, beat_legal, load_data;
   logic [31:0]      next_addr;
   logic [IDX_W-1:0] word_idx;
   logic             unused_hwdata;

   assign unused_hwdata = ^bus.hwdata;

   // A new address phase can only be taken while our own data phase is
   // completing (hreadyout high): IDLE, DATA or the second error cycle.
   assign ready_state = (state_reg == ST_IDLE) || (state_reg == ST_DATA) ||
                        (state_reg == ST_ERR2);
   assign accept      = bus.hsel && bus.hready && bus.htrans[1] && ready_state;
   assign idle_seen   = bus.hsel && bus.hready && ready_state &&
                        (bus.htrans == TRANS_IDLE);
   assign is_nonseq   = (bus.htrans == TRANS_NONSEQ);

   // NONSEQ takes the burst kind from the bus; SEQ continues the stored one.
   assign wrap_sel = is_nonseq ? (bus.hburst == BURST_WRAP4) : burst_wrap_reg;

   assign base_ok = !bus.hwrite && (bus.hsize == HSIZE_WORD) &&
                    (bus.haddr[1:0] == 2'b00) && ((bus.haddr >> ADDR_W) == '0);
   // A SEQ must follow a live burst, hit the predicted address and not be a
   // fifth WRAP4 beat.
   assign seq_ok     = burst_active_reg && (bus.haddr == exp_addr_reg) &&
                       !(burst_wrap_reg && (beat_cnt_reg == 2'd3));
   assign beat_legal = base_ok && (is_nonseq || seq_ok);
   assign load_data  = accept && beat_legal;
   assign word_idx   = bus.haddr[ADDR_W-1:2];

   wrap_addr_gen u_wrap_addr_gen (
      .addr      (bus.haddr),
      .wrap4     (wrap_sel),
      .next_addr (next_addr)
   );

   // State and tracker registers.
   always_ff @(posedge hclk or negedge hrstn) begin
      if (!hrstn) begin
         state_reg        <= ST_IDLE;
         wait_cnt_reg     <= '0;
         beat_cnt_reg     <= '0;
         burst_active_reg <= 1'b0;
         burst_wrap_reg   <= 1'b0;
         exp_addr_reg     <= '0;
         hrdata_reg       <= '0;
      end else begin
         state_reg        <= state_next;
         wait_cnt_reg     <= wait_cnt_next;
         beat_cnt_reg     <= beat_cnt_next;
         burst_active_reg <= burst_active_next;
         burst_wrap_reg   <= burst_wrap_next;
         exp_addr_reg     <= exp_addr_next;
         if (load_data) hrdata_reg <= mem_reg[word_idx];
      end
   end

   // Next state and burst tracker.
   always_comb begin
      state_next        = state_reg;
      wait_cnt_next     = wait_cnt_reg;
      beat_cnt_next     = beat_cnt_reg;
      burst_active_next = burst_active_reg;
      burst_wrap_next   = burst_wrap_reg;
      exp_addr_next     = exp_addr_reg;
      if (accept) begin
         if (!beat_legal) begin
            state_next        = ST_ERR1;
            burst_active_next = 1'b0;
         end else begin
            state_next    = (WAIT_STATES == 0) ? ST_DATA : ST_WAIT;
            wait_cnt_next = WAIT_LOAD;
            exp_addr_next = next_addr;
            if (is_nonseq) begin
               // SINGLE has no continuation, so a later SEQ is illegal.
               burst_active_next = (bus.hburst != BURST_SINGLE);
               burst_wrap_next   = (bus.hburst == BURST_WRAP4);
               beat_cnt_next     = 2'd0;
            end else begin
               beat_cnt_next = beat_cnt_reg + 2'd1;
            end
         end
      end else begin
         // BUSY leaves the tracker alone; IDLE ends the burst.
         if (idle_seen) burst_active_next = 1'b0;
         case (state_reg)
            ST_WAIT: begin
               if (wait_cnt_reg == 3'd0) state_next = ST_DATA;
               else                      wait_cnt_next = wait_cnt_reg - 3'd1;
            end
            ST_ERR1: state_next = ST_ERR2;
            default: state_next = ST_IDLE;
         endcase
      end
   end

   // Outputs are a pure function of state.
   always_comb begin
      bus.hreadyout = 1'b1;
      bus.hresp     = HRESP_OKAY;
      case (state_reg)
         ST_WAIT: bus.hreadyout = 1'b0;
         ST_ERR1: begin
            bus.hreadyout = 1'b0;
            bus.hresp     = HRESP_ERROR;
         end
         ST_ERR2: bus.hresp = HRESP_ERROR;
         default: ;
      endcase
   end

   assign bus.hrdata = hrdata_reg;

endmodule

// File: tb/tb_ahb_imem_slave.sv
// ----------------------------------------------------------------------------
// tb_ahb_imem_slave
// Directed bench for ahb_imem_slave. Three instances (0, 1 and 3 wait states)
// share one set of master signals; sel picks which one is selected and whose
// hreadyout feeds hready back (single-slave bus behaviour).
// ----------------------------------------------------------------------------
module tb_ahb_imem_slave;
   import ahb_imem_slave_pkg::*;

   logic        hclk = 1'b0;
   logic        hrstn = 1'b0;
   logic [1:0]  sel = 2'd0;
   logic        hold = 1'b0;
   logic        hsel_m = 1'b0;
   logic [31:0] haddr_m = '0;
   logic [1:0]  htrans_m = TRANS_IDLE;
   logic [2:0]  hburst_m = BURST_SINGLE;
   logic [2:0]  hsize_m = HSIZE_WORD;
   logic        hwrite_m = 1'b0;
   logic        rdy, resp, hready_bus;
   logic [31:0] rdata;
   int          n_cmp = 0;
   int          n_bad = 0;

   always #5 hclk = ~hclk;

   ahb_imem_slave_if bus0 ();
   ahb_imem_slave_if bus1 ();
   ahb_imem_slave_if bus3 ();

   assign bus0.hsel = hsel_m && (sel == 2'd0);
   assign bus1.hsel = hsel_m && (sel == 2'd1);
   assign bus3.hsel = hsel_m && (sel == 2'd2);
   assign bus0.haddr = haddr_m;   assign bus1.haddr = haddr_m;   assign bus3.haddr = haddr_m;
   assign bus0.htrans = htrans_m; assign bus1.htrans = htrans_m; assign bus3.htrans = htrans_m;
   assign bus0.hburst = hburst_m; assign bus1.hburst = hburst_m; assign bus3.hburst = hburst_m;
   assign bus0.hsize = hsize_m;   assign bus1.hsize = hsize_m;   assign bus3.hsize = hsize_m;
   assign bus0.hwrite = hwrite_m; assign bus1.hwrite = hwrite_m; assign bus3.hwrite = hwrite_m;
   assign bus0.hwdata = 32'hDEAD_BEEF; assign bus1.hwdata = 32'hDEAD_BEEF; assign bus3.hwdata = 32'hDEAD_BEEF;
   assign bus0.hready = hready_bus; assign bus1.hready = hready_bus; assign bus3.hready = hready_bus;

   always_comb begin
      case (sel)
         2'd0: begin rdy = bus0.hreadyout; resp = bus0.hresp; rdata = bus0.hrdata; end
         2'd1: begin rdy = bus1.hreadyout; resp = bus1.hresp; rdata = bus1.hrdata; end
         default: begin rdy = bus3.hreadyout; resp = bus3.hresp; rdata = bus3.hrdata; end
      endcase
   end
   assign hready_bus = rdy & ~hold;

   ahb_imem_slave #(.MEM_WORDS(4096), .WAIT_STATES(0), .INIT_FILE("")) u_ws0 (
      .hclk(hclk), .hrstn(hrstn), .bus(bus0));
   ahb_imem_slave #(.MEM_WORDS(4096), .WAIT_STATES(1), .INIT_FILE("")) u_ws1 (
      .hclk(hclk), .hrstn(hrstn), .bus(bus1));
   ahb_imem_slave #(.MEM_WORDS(4096), .WAIT_STATES(3), .INIT_FILE("")) u_ws3 (
      .hclk(hclk), .hrstn(hrstn), .bus(bus3));

   // Advance to just after the next rising edge.
   task automatic cyc();
      @(posedge hclk);
      #1;
   endtask

   task automatic drive(input logic [1:0] t, input logic [31:0] a, input logic [2:0] b,
                        input logic [2:0] s, input logic w);
      hsel_m = 1'b1; htrans_m = t; haddr_m = a; hburst_m = b; hsize_m = s; hwrite_m = w;
   endtask

   task automatic test_reset();
      #3;
      n_cmp++;
      if ({bus0.hreadyout, bus0.hresp, bus0.hrdata} !== {1'b1, 1'b0, 32'h0}) begin
         n_bad++; $display("FAIL reset_ws0: got %b/%b/%h want 1/0/00000000", bus0.hreadyout, bus0.hresp, bus0.hrdata);
      end
      n_cmp++;
      if ({bus1.hreadyout, bus1.hresp, bus1.hrdata} !== {1'b1, 1'b0, 32'h0}) begin
         n_bad++; $display("FAIL reset_ws1: got %b/%b/%h want 1/0/00000000", bus1.hreadyout, bus1.hresp, bus1.hrdata);
      end
      n_cmp++;
      if ({bus3.hreadyout, bus3.hresp, bus3.hrdata} !== {1'b1, 1'b0, 32'h0}) begin
         n_bad++; $display("FAIL reset_ws3: got %b/%b/%h want 1/0/00000000", bus3.hreadyout, bus3.hresp, bus3.hrdata);
      end
      @(negedge hclk);
      hrstn = 1'b1;
      cyc();
      $display("txn reset: outputs checked on all instances");
   endtask

   task automatic test_wait_read();
      sel = 2'd1;
      drive(TRANS_NONSEQ, 32'h0C, BURST_SINGLE, HSIZE_WORD, 1'b0);
      cyc();
      n_cmp++;
      if ({rdy, resp} !== 2'b00) begin
         n_bad++; $display("FAIL ws1_wait: got rdy/resp=%b/%b want 0/0", rdy, resp);
      end
      htrans_m = TRANS_IDLE;
      cyc();
      n_cmp++;
      if ({rdy, resp, rdata} !== {1'b1, 1'b0, 32'hA5A5_0003}) begin
         n_bad++; $display("FAIL ws1_data: got %b/%b/%h want 1/0/a5a50003", rdy, resp, rdata);
      end
      cyc();
      n_cmp++;
      if ({rdy, resp} !== 2'b10) begin
         n_bad++; $display("FAIL ws1_idle: got rdy/resp=%b/%b want 1/0", rdy, resp);
      end
      $display("txn ws1 read 0x0c: data=%h", rdata);
   endtask

   task automatic test_write_error();
      sel = 2'd1;
      drive(TRANS_NONSEQ, 32'h0, BURST_SINGLE, HSIZE_WORD, 1'b1);
      cyc();
      n_cmp++;
      if ({rdy, resp, rdata} !== {1'b0, 1'b1, 32'hA5A5_0003}) begin
         n_bad++; $display("FAIL wr_err1: got %b/%b/%h want 0/1/a5a50003", rdy, resp, rdata);
      end
      htrans_m = TRANS_IDLE; hwrite_m = 1'b0;
      cyc();
      n_cmp++;
      if ({rdy, resp, rdata} !== {1'b1, 1'b1, 32'hA5A5_0003}) begin
         n_bad++; $display("FAIL wr_err2: got %b/%b/%h want 1/1/a5a50003", rdy, resp, rdata);
      end
      cyc();
      n_cmp++;
      if ({rdy, resp} !== 2'b10) begin
         n_bad++; $display("FAIL wr_idle: got rdy/resp=%b/%b want 1/0", rdy, resp);
      end
      $display("txn ws1 write 0x00: error response");
   endtask

   task automatic test_wrap_burst();
      logic [31:0] addrs [4] = '{32'h3C, 32'h30, 32'h34, 32'h38};
      logic [31:0] datas [4] = '{32'hC0DE_000E, 32'hC0DE_000F, 32'hC0DE_000C, 32'hC0DE_000D};
      sel = 2'd0;
      drive(TRANS_NONSEQ, 32'h38, BURST_WRAP4, HSIZE_WORD, 1'b0);
      for (int i = 0; i < 4; i++) begin
         cyc();
         n_cmp++;
         if ({rdy, resp, rdata} !== {1'b1, 1'b0, datas[i]}) begin
            n_bad++; $display("FAIL wrap_beat%0d: got %b/%b/%h want 1/0/%h", i, rdy, resp, rdata, datas[i]);
         end
         $display("txn ws0 wrap4 beat %0d: data=%h", i, rdata);
         drive(TRANS_SEQ, addrs[i], BURST_WRAP4, HSIZE_WORD, 1'b0);
      end
      // Fifth WRAP4 beat (0x38) is refused.
      cyc();
      n_cmp++;
      if ({rdy, resp, rdata} !== {1'b0, 1'b1, 32'hC0DE_000D}) begin
         n_bad++; $display("FAIL wrap_fifth_err1: got %b/%b/%h want 0/1/c0de000d", rdy, resp, rdata);
      end
      htrans_m = TRANS_IDLE;
      cyc();
      n_cmp++;
      if ({rdy, resp} !== 2'b11) begin
         n_bad++; $display("FAIL wrap_fifth_err2: got rdy/resp=%b/%b want 1/1", rdy, resp);
      end
      cyc();
      n_cmp++;
      if ({rdy, resp} !== 2'b10) begin
         n_bad++; $display("FAIL wrap_fifth_idle: got rdy/resp=%b/%b want 1/0", rdy, resp);
      end
      $display("txn ws0 wrap4 fifth beat: error response");
   endtask

   task automatic test_wrap_break();
      sel = 2'd0;
      drive(TRANS_NONSEQ, 32'h10, BURST_WRAP4, HSIZE_WORD, 1'b0);
      cyc();
      n_cmp++;
      if ({rdy, resp, rdata} !== {1'b1, 1'b0, 32'hC0DE_0004}) begin
         n_bad++; $display("FAIL brk_first: got %b/%b/%h want 1/0/c0de0004", rdy, resp, rdata);
      end
      drive(TRANS_SEQ, 32'h18, BURST_WRAP4, HSIZE_WORD, 1'b0);
      cyc();
      n_cmp++;
      if ({rdy, resp, rdata} !== {1'b0, 1'b1, 32'hC0DE_0004}) begin
         n_bad++; $display("FAIL brk_err1: got %b/%b/%h want 0/1/c0de0004", rdy, resp, rdata);
      end
      htrans_m = TRANS_IDLE;
      cyc();
      n_cmp++;
      if ({rdy, resp} !== 2'b11) begin
         n_bad++; $display("FAIL brk_err2: got rdy/resp=%b/%b want 1/1", rdy, resp);
      end
      // After the error, even the address the burst would have used is a stray SEQ.
      drive(TRANS_SEQ, 32'h14, BURST_WRAP4, HSIZE_WORD, 1'b0);
      cyc();
      n_cmp++;
      if ({rdy, resp, rdata} !== {1'b0, 1'b1, 32'hC0DE_0004}) begin
         n_bad++; $display("FAIL brk_stray_err1: got %b/%b/%h want 0/1/c0de0004", rdy, resp, rdata);
      end
      htrans_m = TRANS_IDLE;
      cyc();
      n_cmp++;
      if ({rdy, resp} !== 2'b11) begin
         n_bad++; $display("FAIL brk_stray_err2: got rdy/resp=%b/%b want 1/1", rdy, resp);
      end
      cyc();
      n_cmp++;
      if ({rdy, resp} !== 2'b10) begin
         n_bad++; $display("FAIL brk_idle: got rdy/resp=%b/%b want 1/0", rdy, resp);
      end
      $display("txn ws0 wrap4 broken at 0x18: error, stray SEQ 0x14: error");
   endtask

   task automatic test_range_busy();
      logic [31:0] bad_addr [3] = '{32'h4000, 32'h2, 32'h8};
      logic [2:0]  bad_size [3] = '{HSIZE_WORD, HSIZE_WORD, 3'b000};
      sel = 2'd0;
      for (int i = 0; i < 3; i++) begin
         drive(TRANS_NONSEQ, bad_addr[i], BURST_SINGLE, bad_size[i], 1'b0);
         cyc();
         n_cmp++;
         if ({rdy, resp, rdata} !== {1'b0, 1'b1, 32'hC0DE_0004}) begin
            n_bad++; $display("FAIL illegal%0d_err1: got %b/%b/%h want 0/1/c0de0004", i, rdy, resp, rdata);
         end
         htrans_m = TRANS_IDLE;
         cyc();
         n_cmp++;
         if ({rdy, resp} !== 2'b11) begin
            n_bad++; $display("FAIL illegal%0d_err2: got rdy/resp=%b/%b want 1/1", i, rdy, resp);
         end
         cyc();
         $display("txn ws0 illegal read addr=%h size=%0d: error response", bad_addr[i], bad_size[i]);
      end
      drive(TRANS_NONSEQ, 32'h20, BURST_WRAP4, HSIZE_WORD, 1'b0);
      cyc();
      n_cmp++;
      if ({rdy, resp, rdata} !== {1'b1, 1'b0, 32'hC0DE_0008}) begin
         n_bad++; $display("FAIL busy_first: got %b/%b/%h want 1/0/c0de0008", rdy, resp, rdata);
      end
      drive(TRANS_BUSY, 32'h24, BURST_WRAP4, HSIZE_WORD, 1'b0);
      cyc();
      n_cmp++;
      if ({rdy, resp, rdata} !== {1'b1, 1'b0, 32'hC0DE_0008}) begin
         n_bad++; $display("FAIL busy_okay: got %b/%b/%h want 1/0/c0de0008", rdy, resp, rdata);
      end
      drive(TRANS_SEQ, 32'h24, BURST_WRAP4, HSIZE_WORD, 1'b0);
      cyc();
      n_cmp++;
      if ({rdy, resp, rdata} !== {1'b1, 1'b0, 32'hC0DE_0009}) begin
         n_bad++; $display("FAIL busy_resume: got %b/%b/%h want 1/0/c0de0009", rdy, resp, rdata);
      end
      htrans_m = TRANS_IDLE;
      cyc();
      $display("txn ws0 wrap4 with BUSY: data=%h", rdata);
   endtask

   task automatic test_hready_low();
      sel = 2'd0;
      hold = 1'b1;
      drive(TRANS_NONSEQ, 32'h0C, BURST_SINGLE, HSIZE_WORD, 1'b0);
      cyc();
      n_cmp++;
      if ({rdy, resp, rdata} !== {1'b1, 1'b0, 32'hC0DE_0009}) begin
         n_bad++; $display("FAIL hold_ignored: got %b/%b/%h want 1/0/c0de0009", rdy, resp, rdata);
      end
      hold = 1'b0;
      htrans_m = TRANS_IDLE;
      cyc();
      n_cmp++;
      if ({rdy, resp, rdata} !== {1'b1, 1'b0, 32'hC0DE_0009}) begin
         n_bad++; $display("FAIL hold_not_queued: got %b/%b/%h want 1/0/c0de0009", rdy, resp, rdata);
      end
      $display("txn ws0 read with hready low: ignored");
   endtask

   task automatic test_reset_mid_wait();
      sel = 2'd2;
      drive(TRANS_NONSEQ, 32'h14, BURST_SINGLE, HSIZE_WORD, 1'b0);
      cyc();
      htrans_m = TRANS_IDLE;
      n_cmp++;
      if ({rdy, resp} !== 2'b00) begin
         n_bad++; $display("FAIL ws3_pre_reset_wait: got rdy/resp=%b/%b want 0/0", rdy, resp);
      end
      #2;
      hrstn = 1'b0;
      #1;
      n_cmp++;
      if ({rdy, resp, rdata} !== {1'b1, 1'b0, 32'h0}) begin
         n_bad++; $display("FAIL ws3_async_reset: got %b/%b/%h want 1/0/00000000", rdy, resp, rdata);
      end
      #2;
      hrstn = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cyc();
         n_cmp++;
         if ({rdy, resp, rdata} !== {1'b1, 1'b0, 32'h0}) begin
            n_bad++; $display("FAIL ws3_abandoned%0d: got %b/%b/%h want 1/0/00000000", i, rdy, resp, rdata);
         end
      end
      drive(TRANS_NONSEQ, 32'h14, BURST_SINGLE, HSIZE_WORD, 1'b0);
      for (int i = 0; i < 3; i++) begin
         cyc();
         htrans_m = TRANS_IDLE;
         n_cmp++;
         if ({rdy, resp} !== 2'b00) begin
            n_bad++; $display("FAIL ws3_wait%0d: got rdy/resp=%b/%b want 0/0", i, rdy, resp);
         end
      end
      cyc();
      n_cmp++;
      if ({rdy, resp, rdata} !== {1'b1, 1'b0, 32'h3333_0005}) begin
         n_bad++; $display("FAIL ws3_data: got %b/%b/%h want 1/0/33330005", rdy, resp, rdata);
      end
      cyc();
      n_cmp++;
      if ({rdy, resp} !== 2'b10) begin
         n_bad++; $display("FAIL ws3_idle: got rdy/resp=%b/%b want 1/0", rdy, resp);
      end
      $display("txn ws3 reset mid-wait then read 0x14: data=%h", rdata);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 16; i++) u_ws0.mem_reg[i] = 32'hC0DE_0000 + 32'(i);
      u_ws1.mem_reg[3] = 32'hA5A5_0003;
      u_ws3.mem_reg[5] = 32'h3333_0005;
      test_reset();
      test_wait_read();
      test_write_error();
      test_wrap_burst();
      test_wrap_break();
      test_range_busy();
      test_hready_low();
      test_reset_mid_wait();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
